// File: rtl/load_seq.sv
// Write-command sequencer: buffers {addr, data} commands in a FIFO and issues one
// single-cycle load strobe per cycle toward the 4-way demux. Optional macro: LOAD_SEQ_BYPASS_EN.
module load_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_addr,
    input  logic [WIDTH-1:0]         i_cmd_data,
    input  logic                     i_stall,
    output logic                     o_load,
    output logic [1:0]               o_sel,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]       addr;
        logic [WIDTH-1:0] data;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_load;
    logic [1:0]    r_sel;
    logic [WIDTH-1:0] r_data;

    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_fifo_wr;
    cmd_t w_in;
    cmd_t w_head;

    // Ready depends only on registered occupancy, never on valid or stall.
    assign o_cmd_ready = (r_count < CW'(DEPTH));
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_pop       = (r_count != '0) && !i_stall;

`ifdef LOAD_SEQ_BYPASS_EN
    // An empty queue lets a fresh command skip the FIFO; a non-empty head always wins.
    assign w_bypass = w_push && (r_count == '0) && !i_stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_wr = w_push && !w_bypass;
    assign w_in      = {i_cmd_addr, i_cmd_data};
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; stale entries are unreachable once the pointers and count clear.
    always_ff @(posedge i_clk) begin
        if (w_fifo_wr && !i_reset) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_load   <= 1'b0;
            r_sel    <= 2'b00;
            r_data   <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_load <= 1'b1;
                r_sel  <= w_head.addr;
                r_data <= w_head.data;
            end else if (w_bypass) begin
                r_load <= 1'b1;
                r_sel  <= w_in.addr;
                r_data <= w_in.data;
            end else begin
                r_load <= 1'b0;
            end
        end
    end

    assign o_load  = r_load;
    assign o_sel   = r_sel;
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: tb/tb_load_seq.sv
// Scoreboard bench for load_seq: stimulus queues expected {sel, data}; a monitor
// pops and compares on every load strobe. Honours LOAD_SEQ_BYPASS_EN for latency.
module tb_load_seq;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

`ifdef LOAD_SEQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_addr;
    logic [WIDTH-1:0] i_cmd_data;
    logic             i_stall;
    logic             o_load;
    logic [1:0]       o_sel;
    logic [WIDTH-1:0] o_data;
    logic [2:0]       o_count;

    logic [17:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    load_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_data  (i_cmd_data),
        .i_stall     (i_stall),
        .o_load      (o_load),
        .o_sel       (o_sel),
        .o_data      (o_data),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding command.
    initial begin
        forever begin
            @(negedge clk);
            if (o_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 32'(o_load), 32'd0);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("sel", 32'(o_sel), 32'(e[17:16]));
                    check("data", 32'(o_data), 32'(e[15:0]));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] a, input logic [15:0] d);
        int n;
        n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_addr  = a;
        i_cmd_data  = d;
        while (o_cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            exp_q.push_back({a, d});
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_idle"}, 32'(o_load), 32'd0);
    endtask

    // Single command into an empty queue: load high exactly one cycle at base latency.
    task automatic latency_probe(input string name, input logic [1:0] a, input logic [15:0] d);
        send(a, d);
        check({name, "_n1"}, 32'(o_load), BYPASS ? 32'd1 : 32'd0);
        @(negedge clk);
        check({name, "_n2"}, 32'(o_load), BYPASS ? 32'd0 : 32'd1);
        @(negedge clk);
        check({name, "_n3"}, 32'(o_load), 32'd0);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 2'b11;
        i_cmd_data  = 16'hFFFF;
        i_stall     = 1'b0;

        // Reset held two cycles with a command presented.
        repeat (2) @(negedge clk);
        check("rst_load", 32'(o_load), 32'd0);
        check("rst_sel", 32'(o_sel), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        i_reset     = 1'b0;
        i_cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_count", 32'(o_count), 32'd0);
        end

        latency_probe("single", 2'b10, 16'hBEEF);
        check("single_sel_hold", 32'(o_sel), 32'd2);
        check("single_data_hold", 32'(o_data), 32'hBEEF);

        // Fill under stall, then a 5th command is held until space appears.
        i_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(2'(i), 16'hA000 + 16'(i));
        check("full_count", 32'(o_count), 32'd4);
        check("full_ready", 32'(o_cmd_ready), 32'd0);
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 2'b01;
        i_cmd_data  = 16'h5555;
        repeat (2) begin
            @(negedge clk);
            check("held_count", 32'(o_count), 32'd4);
            check("held_load", 32'(o_load), 32'd0);
        end
        i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("burst_load", 32'(o_load), 32'd1);
            if (i == 0) begin
                check("drop_count", 32'(o_count), 32'd3);
                check("drop_ready", 32'(o_cmd_ready), 32'd1);
                exp_q.push_back({2'b01, 16'h5555});
            end else if (i == 1) begin
                i_cmd_valid = 1'b0;
                check("pushpop_count", 32'(o_count), 32'd3);
            end
        end
        drain("fill_drain");

        // Full-rate stream: occupancy stays flat once filled.
        for (int i = 0; i < 8; i++) begin
            send(2'(i), 16'h1000 + 16'(i));
            if (i >= 1) check("stream_count", 32'(o_count), BYPASS ? 32'd0 : 32'd1);
        end
        drain("stream_drain");

        // Ten commands with random stall crossing the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            i_stall = 1'($urandom_range(0, 1));
            send(2'(3 - (i % 4)), 16'hC0DE ^ 16'(i * 16'h0111));
        end
        i_stall = 1'b0;
        drain("wrap_drain");

        // Reset with three commands queued.
        i_stall = 1'b1;
        send(2'b00, 16'h0101);
        send(2'b01, 16'h0202);
        send(2'b10, 16'h0303);
        check("pre_rst_count", 32'(o_count), 32'd3);
        i_reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        i_reset = 1'b0;
        i_stall = 1'b0;
        check("midrst_count", 32'(o_count), 32'd0);
        check("midrst_ready", 32'(o_cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("midrst_load", 32'(o_load), 32'd0);
        end
        latency_probe("after_rst", 2'b11, 16'h1234);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_seq.md
# load_seq

Write-command sequencer that sits directly upstream of the 4-way load demultiplexer in the memory path. It accepts write commands (2-bit word address plus data) over a valid/ready handshake and buffers them in a small FIFO. It then issues at most one command per cycle as a single-cycle `load` strobe with a registered `sel` and `data`. The `load` and `sel` outputs feed the demux `in` and `sel` inputs, and `data` goes to the four destination registers.

## Interface
- `WIDTH`, default 16: data word width.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command this cycle.
- `cmd_addr` in 2: destination select (00..11).
- `cmd_data` in WIDTH: write data.
- `stall` in 1: downstream not accepting; no issue this cycle.
- `load` out 1: one-cycle write strobe, drives demux `in`.
- `sel` out 2: destination of the current/last issue, drives demux `sel`.
- `data` out WIDTH: data of the current/last issue.
- `count` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

## Operation
- Push: the handshake completes when `cmd_valid && cmd_ready`. The `{cmd_addr, cmd_data}` pair is written at the tail.
- `cmd_ready = (count < DEPTH)`. It is combinational from the registered count and does not depend on `cmd_valid` or `stall`.
- Issue condition: `count != 0 && !stall`.
  - On the edge, the head is popped into the output registers with `load <= 1`, `sel <= head.addr`, `data <= head.data`.
- No issue in a cycle gives `load <= 0`. `sel` and `data` hold their last values.
- `load` is never high for two cycles from one command. Back-to-back issues give `load` high on consecutive cycles, with `sel` and `data` updated each cycle.
- Simultaneous push and pop: allowed whenever `count < DEPTH`. `count` stays unchanged and ordering is preserved (strict FIFO).
  - When full, `cmd_ready=0`, so no push occurs even if a pop happens in that cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is kept separately to distinguish full from empty.
- `cmd_valid` while `cmd_ready=0`: nothing is accepted. The sender must hold the command; the block does not drop it or flag an error.
- `stall` only blocks issue. Pushes continue until the FIFO is full.
- Reset, including mid-operation:
  - All queued commands are discarded. Pointers are cleared and `count=0`.
  - `load=0`, `sel=2'b00`, `data=0`.
  - `cmd_ready=1` in the first cycle after reset.
  - A push in the same cycle as `reset` is ignored.

## Timing
- Base latency: a command accepted in cycle N is written to the FIFO at the end of N.
  - The earliest pop decision is in cycle N+1.
  - `load` is high in cycle N+2.
- Throughput: one command per cycle sustained when `stall=0`.
- `stall` is sampled in the same cycle as the pop decision.
  - `stall=1` in cycle K means `load=0` in cycle K+1.
  - Deasserting `stall` in cycle K lets `load` go high in K+1 if `count != 0`.
- Outputs `load`, `sel`, `data` and `count` are all registered. `cmd_ready` is the only combinational output.

## Configuration
- Macro `LOAD_SEQ_BYPASS_EN`.
- Defined: bypass path enabled.
  - Applies when `count == 0`, `!stall` and a push is accepted in cycle N.
  - The command goes straight into the output registers at the end of N, giving `load` high in N+1.
  - The FIFO is not written and `count` stays 0.
  - When `count != 0`, the FIFO head always has priority, so order is preserved.
- Undefined: no bypass. Every command passes through the FIFO with a minimum latency of 2 cycles as above.

## Test plan
- Reset: assert `reset` for 2 cycles with `cmd_valid=1` -> `load=0`, `sel=00`, `data=0`, `count=0`, `cmd_ready=1`; nothing is issued afterwards.
- Single write: push addr=10, data=16'hBEEF in cycle N with `stall=0` -> `load=1`, `sel=10`, `data=BEEF` in N+2 only (N+1 with `LOAD_SEQ_BYPASS_EN`); `load=0` after.
- Fill under stall: `stall=1`, push 4 commands addr 00,01,10,11 -> `count=4`, `cmd_ready=0`, and a 5th command is held, not accepted. Release `stall` -> 4 consecutive `load` pulses with `sel` 00,01,10,11 in order. The 5th command is accepted the cycle `count` drops to 3.
- Simultaneous push/pop: stream 8 commands at full rate with `stall=0` -> `count` constant after fill, 8 issues in order, data matches.
- Pointer wrap: issue 10 commands with random `stall` -> output order and data equal input order, with no loss or duplication across the pointer wrap.
- Reset mid-operation: with `count=3`, pulse `reset` -> queue emptied, no further `load`, and a fresh command afterwards issues with the base latency.
